// File: rtl/stl_rf_wb_arb.sv
// Write-back controller for the RV32E register file.
// Round-robin arbitration of two write-back requesters onto one write port.
// The winner becomes a registered one-hot write enable plus a broadcast data bus.
// A busy scoreboard is set at issue and cleared on the edge where the array writes.
// Optional performance counters are enabled by defining STL_RFARB_PERF_EN.
module stl_rf_wb_arb #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 16,
   parameter int unsigned AW   = 4
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_rsv_valid,
   input  logic [AW-1:0]   i_rsv_rd,
   output logic            o_rsv_ready,
   input  logic [AW-1:0]   i_rs1,
   input  logic [AW-1:0]   i_rs2,
   output logic            o_rs1_busy,
   output logic            o_rs2_busy,
   input  logic            i_a_valid,
   input  logic [AW-1:0]   i_a_rd,
   input  logic [XLEN-1:0] i_a_data,
   output logic            o_a_ready,
   input  logic            i_b_valid,
   input  logic [AW-1:0]   i_b_rd,
   input  logic [XLEN-1:0] i_b_data,
   output logic            o_b_ready,
   output logic [NREG-1:0] o_wen,
   output logic [XLEN-1:0] o_wdata,
   output logic [NREG-1:0] o_busy_vec
`ifdef STL_RFARB_PERF_EN
   ,
   output logic [31:0]     o_conflict_cnt,
   output logic [31:0]     o_wb_cnt
`endif
);

   typedef enum logic {PtrA, PtrB} ptr_e;

   ptr_e            ptr_q, ptr_d;
   logic [NREG-1:0] busy_q, busy_d;
   logic [NREG-1:0] wen_q, wen_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic            grant_a, grant_b;

   // x0 and out-of-range indices decode to no enable at all.
   function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] idx);
      logic [NREG-1:0] oh;
      oh = '0;
      if (idx != '0 && 32'(idx) < NREG) begin
         oh[idx] = 1'b1;
      end
      return oh;
   endfunction

   // Lookup through the decoder so x0 and out-of-range read as not busy.
   function automatic logic busy_of(input logic [NREG-1:0] vec, input logic [AW-1:0] idx);
      return (vec & onehot(idx)) != '0;
   endfunction

   // Arbitration, hazard lookup and next-state computation.
   always_comb begin
      grant_a     = i_a_valid && (!i_b_valid || ptr_q == PtrA);
      grant_b     = i_b_valid && (!i_a_valid || ptr_q == PtrB);
      o_rsv_ready = i_rsv_valid && !busy_of(busy_q, i_rsv_rd);
      o_rs1_busy  = busy_of(busy_q, i_rs1);
      o_rs2_busy  = busy_of(busy_q, i_rs2);

      ptr_d = ptr_q;
      if (grant_a) begin
         ptr_d = PtrB;
      end else if (grant_b) begin
         ptr_d = PtrA;
      end

      wen_d   = '0;
      wdata_d = wdata_q;
      if (grant_a) begin
         wen_d   = onehot(i_a_rd);
         wdata_d = i_a_data;
      end else if (grant_b) begin
         wen_d   = onehot(i_b_rd);
         wdata_d = i_b_data;
      end

      // Clear follows the registered enable so it lands with the array write; a
      // same-rd reservation in that cycle was already refused by the old busy bit.
      busy_d = busy_q & ~wen_q;
      if (o_rsv_ready) begin
         busy_d = busy_d | onehot(i_rsv_rd);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr_q   <= PtrA;
         busy_q  <= '0;
         wen_q   <= '0;
         wdata_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
      end
   end

   assign o_a_ready  = grant_a;
   assign o_b_ready  = grant_b;
   assign o_wen      = wen_q;
   assign o_wdata    = wdata_q;
   assign o_busy_vec = busy_q;

`ifdef STL_RFARB_PERF_EN
   logic [31:0] conflict_cnt_q, conflict_cnt_d;
   logic [31:0] wb_cnt_q, wb_cnt_d;

   // Free-running event counters; wrap naturally at 2^32.
   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      wb_cnt_d       = wb_cnt_q;
      if (i_a_valid && i_b_valid) begin
         conflict_cnt_d = conflict_cnt_q + 32'd1;
      end
      if (grant_a || grant_b) begin
         wb_cnt_d = wb_cnt_q + 32'd1;
      end
   end

   // Counter registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         conflict_cnt_q <= '0;
         wb_cnt_q       <= '0;
      end else begin
         conflict_cnt_q <= conflict_cnt_d;
         wb_cnt_q       <= wb_cnt_d;
      end
   end

   assign o_conflict_cnt = conflict_cnt_q;
   assign o_wb_cnt       = wb_cnt_q;
`endif

endmodule

// File: tb/tb_stl_rf_wb_arb.sv
// Directed self-checking bench for stl_rf_wb_arb.
// Perf counter checks are compiled in when STL_RFARB_PERF_EN is defined.
module tb_stl_rf_wb_arb;

   logic        clk;
   logic        rst;
   logic        rsv_valid;
   logic [3:0]  rsv_rd;
   logic        rsv_ready;
   logic [3:0]  rs1, rs2;
   logic        rs1_busy, rs2_busy;
   logic        a_valid, b_valid;
   logic [3:0]  a_rd, b_rd;
   logic [31:0] a_data, b_data;
   logic        a_ready, b_ready;
   logic [15:0] wen;
   logic [31:0] wdata;
   logic [15:0] busy_vec;
`ifdef STL_RFARB_PERF_EN
   logic [31:0] conflict_cnt, wb_cnt;
`endif

   int total = 0;
   int bad   = 0;

   stl_rf_wb_arb dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_rsv_valid   (rsv_valid),
      .i_rsv_rd      (rsv_rd),
      .o_rsv_ready   (rsv_ready),
      .i_rs1         (rs1),
      .i_rs2         (rs2),
      .o_rs1_busy    (rs1_busy),
      .o_rs2_busy    (rs2_busy),
      .i_a_valid     (a_valid),
      .i_a_rd        (a_rd),
      .i_a_data      (a_data),
      .o_a_ready     (a_ready),
      .i_b_valid     (b_valid),
      .i_b_rd        (b_rd),
      .i_b_data      (b_data),
      .o_b_ready     (b_ready),
      .o_wen         (wen),
      .o_wdata       (wdata),
      .o_busy_vec    (busy_vec)
`ifdef STL_RFARB_PERF_EN
      ,
      .o_conflict_cnt(conflict_cnt),
      .o_wb_cnt      (wb_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; rsv_valid = 1'b0; rsv_rd = '0; rs1 = '0; rs2 = '0;
      a_valid = 1'b0; a_rd = '0; a_data = '0;
      b_valid = 1'b0; b_rd = '0; b_data = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_wen", 32'(wen), 32'h0);
      chk("reset_wdata", wdata, 32'h0);
      chk("reset_busy", 32'(busy_vec), 32'h0);

      // Reset mid-write.
      a_valid = 1'b1; a_rd = 4'd5; a_data = 32'hDEADBEEF;
      #1 chk("midrst_a_ready", 32'(a_ready), 32'h1);
      tick();
      a_valid = 1'b0;
      chk("midrst_wen_pre", 32'(wen), 32'h0020);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_wen", 32'(wen), 32'h0);
      chk("midrst_wdata", wdata, 32'h0);
      chk("midrst_busy", 32'(busy_vec), 32'h0);

      // Contention: pointer back at A after reset, so A,B,A,B.
      a_valid = 1'b1; a_rd = 4'd1; a_data = 32'h11111111;
      b_valid = 1'b1; b_rd = 4'd2; b_data = 32'h22222222;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_a_ready", 32'(a_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
         chk("rr_b_ready", 32'(b_ready), (i % 2 == 0) ? 32'h0 : 32'h1);
         tick();
         chk("rr_wen", 32'(wen), (i % 2 == 0) ? 32'h0002 : 32'h0004);
      end
      a_valid = 1'b0; b_valid = 1'b0;
      tick();
      chk("idle_wen", 32'(wen), 32'h0);
      chk("idle_wdata_hold", wdata, 32'h22222222);

      // Single write with reservation.
      rsv_valid = 1'b1; rsv_rd = 4'd3;
      #1 chk("sw_rsv_ready", 32'(rsv_ready), 32'h1);
      tick();
      rsv_valid = 1'b0; rs1 = 4'd3;
      chk("sw_busy_set", 32'(busy_vec), 32'h0008);
      #1 chk("sw_rs1_busy", 32'(rs1_busy), 32'h1);
      a_valid = 1'b1; a_rd = 4'd3; a_data = 32'h12345678;
      #1 chk("sw_a_ready", 32'(a_ready), 32'h1);
      tick();
      a_valid = 1'b0;
      chk("sw_wen", 32'(wen), 32'h0008);
      chk("sw_wdata", wdata, 32'h12345678);
      chk("sw_busy_still", 32'(busy_vec), 32'h0008);
      tick();
      chk("sw_busy_clr", 32'(busy_vec), 32'h0);
      chk("sw_wen_off", 32'(wen), 32'h0);

      // x0 handling.
      b_valid = 1'b1; b_rd = 4'd0; b_data = 32'hFFFFFFFF;
      #1 chk("x0_b_ready", 32'(b_ready), 32'h1);
      tick();
      b_valid = 1'b0;
      chk("x0_wen", 32'(wen), 32'h0);
      chk("x0_wdata", wdata, 32'hFFFFFFFF);
      rsv_valid = 1'b1; rsv_rd = 4'd0; rs1 = 4'd0;
      #1 chk("x0_rsv_ready", 32'(rsv_ready), 32'h1);
      chk("x0_rs1_busy", 32'(rs1_busy), 32'h0);
      tick();
      rsv_valid = 1'b0;
      chk("x0_busy", 32'(busy_vec), 32'h0);

      // WAW block on rd=7.
      rsv_valid = 1'b1; rsv_rd = 4'd7;
      tick();
      rsv_valid = 1'b0; rs2 = 4'd7;
      chk("waw_busy_set", 32'(busy_vec), 32'h0080);
      #1 chk("waw_rs2_busy", 32'(rs2_busy), 32'h1);
      a_valid = 1'b1; a_rd = 4'd7; a_data = 32'h77777777;
      tick();
      a_valid = 1'b0;
      rsv_valid = 1'b1; rsv_rd = 4'd7;
      #1 chk("waw_rsv_refused", 32'(rsv_ready), 32'h0);
      tick();
      chk("waw_busy_clr", 32'(busy_vec), 32'h0);
      #1 chk("waw_rsv_retry", 32'(rsv_ready), 32'h1);
      tick();
      rsv_valid = 1'b0;
      chk("waw_busy_again", 32'(busy_vec), 32'h0080);

      // Clear rd=7 and reserve rd=9 at the same edge.
      a_valid = 1'b1; a_rd = 4'd7; a_data = 32'h70707070;
      tick();
      a_valid = 1'b0;
      rsv_valid = 1'b1; rsv_rd = 4'd9;
      #1 chk("diff_rsv_ready", 32'(rsv_ready), 32'h1);
      tick();
      rsv_valid = 1'b0;
      chk("diff_busy", 32'(busy_vec), 32'h0200);

`ifdef STL_RFARB_PERF_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("perf_conf_rst", conflict_cnt, 32'h0);
      chk("perf_wb_rst", wb_cnt, 32'h0);
      a_valid = 1'b1; a_rd = 4'd1; b_valid = 1'b1; b_rd = 4'd2;
      tick();
      tick();
      tick();
      b_valid = 1'b0;
      tick();
      a_valid = 1'b0;
      chk("perf_conflict", conflict_cnt, 32'd3);
      chk("perf_wb", wb_cnt, 32'd4);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
